// File: rtl/int2float_iter.sv
// Multi-cycle signed 32-bit integer to IEEE-754 single conversion (CVT.S.W).
// Normalises with coarse/fine left shifts, then rounds per the latched FCSR mode.
module int2float_iter #(
    parameter int SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_int,
    input  logic [1:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_float,
    output logic        out_inexact
);

    // Handshake: an operand transfers on in_valid & in_ready (only in IDLE);
    // a result transfers on out_valid & out_ready (only in DONE) and stays
    // stable until then. flush drops whatever is in flight.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] RM_RN = 2'd0;
    localparam logic [1:0] RM_RZ = 2'd1;
    localparam logic [1:0] RM_RP = 2'd2;

    logic [1:0]  state;
    logic        sign;
    logic [31:0] mag;
    logic [7:0]  expn;
    logic [1:0]  rm;

    logic        coarse_ok;
    logic [22:0] frac;
    logic        g_bit;
    logic        s_bit;
    logic        lsb_bit;
    logic        inc;
    logic [22:0] frac_rnd;
    logic [7:0]  exp_rnd;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // A whole coarse step is safe only when none of its bits would leave the top.
    assign coarse_ok = (mag[31 -: SHIFT_STEP] == '0);

    always_comb begin
        frac    = mag[30:8];
        g_bit   = mag[7];
        s_bit   = |mag[6:0];
        lsb_bit = mag[8];
        case (rm)
            RM_RN:   inc = g_bit & (s_bit | lsb_bit);
            RM_RZ:   inc = 1'b0;
            RM_RP:   inc = ~sign & (g_bit | s_bit);
            default: inc = sign & (g_bit | s_bit);
        endcase
        // Mantissa carry-out wraps frac to zero and bumps the exponent; at most 159.
        frac_rnd = frac + {22'd0, inc};
        exp_rnd  = expn + {7'd0, (inc && (frac == 23'h7FFFFF))};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sign        <= 1'b0;
            mag         <= 32'd0;
            expn        <= 8'd0;
            rm          <= 2'd0;
            out_float   <= 32'd0;
            out_inexact <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= in_int[31];
                        mag  <= in_int[31] ? (~in_int + 32'd1) : in_int;
                        expn <= 8'd158;
                        rm   <= in_rm;
                        if (in_int == 32'd0) begin
                            out_float   <= 32'd0;
                            out_inexact <= 1'b0;
                            state       <= DONE;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[31]) begin
                        state <= ROUND;
                    end else if (coarse_ok) begin
                        mag  <= mag << SHIFT_STEP;
                        expn <= expn - 8'(SHIFT_STEP);
                    end else begin
                        mag  <= mag << 1;
                        expn <= expn - 8'd1;
                    end
                end
                ROUND: begin
                    out_float   <= {sign, exp_rnd, frac_rnd};
                    out_inexact <= g_bit | s_bit;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int2float_iter.sv
// Self-checking bench for int2float_iter: directed corner cases from the
// conversion rules plus randomized operands against an arithmetic reference.
module tb_int2float_iter;

    localparam int STEP = 8;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_int;
    logic [1:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic        out_inexact;

    int n_checks;
    int n_errors;
    logic [32:0] exp_q[$];

    int2float_iter #(.SHIFT_STEP(STEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_int     (in_int),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_float  (out_float),
        .out_inexact(out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Position of the leading one of |v| (v nonzero).
    function automatic int top_bit(input logic [31:0] v);
        longint m;
        int e;
        m = v[31] ? ((longint'(1) << 32) - longint'(v)) : longint'(v);
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        return e;
    endfunction

    function automatic int lat_ref(input logic [31:0] v);
        int lz;
        if (v == 32'd0) return 1;
        lz = 31 - top_bit(v);
        return 3 + lz / STEP + lz % STEP;
    endfunction

    // Returns {inexact, float}: exact integer division into quotient and remainder.
    function automatic logic [32:0] ref_cvt(input logic [31:0] v, input logic [1:0] rm);
        longint m, q, rem, half;
        int e, sh;
        bit s, inc;
        if (v == 32'd0) return 33'd0;
        s = v[31];
        m = s ? ((longint'(1) << 32) - longint'(v)) : longint'(v);
        e = top_bit(v);
        rem = 0;
        half = 0;
        inc = 0;
        if (e <= 23) begin
            q = m << (23 - e);
        end else begin
            sh = e - 23;
            q = m >> sh;
            rem = m & ((longint'(1) << sh) - 1);
            half = longint'(1) << (sh - 1);
            case (rm)
                2'd0: inc = (rem > half) || (rem == half && q[0]);
                2'd1: inc = 0;
                2'd2: inc = !s && rem != 0;
                default: inc = s && rem != 0;
            endcase
        end
        q = q + longint'(inc);
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e++;
        end
        return {(rem != 0), s, 8'(e + 127), 23'(q)};
    endfunction

    // Drive one operand, check latency, result, backpressure hold and release.
    task automatic run_op(input logic [31:0] v, input logic [1:0] rm, input logic [31:0] ef,
                          input logic ei, input int el, input int hold);
        int cyc;
        bit seen;
        logic [32:0] e;
        @(negedge clk);
        check("ready_before_op", in_ready, 1);
        in_valid = 1'b1;
        in_int = v;
        in_rm = rm;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_int = $urandom;
        in_rm = 2'($urandom_range(0, 3));
        exp_q.push_back({ei, ef});
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                seen = 1;
                in_valid = 1'b0;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_int = $urandom;
                in_rm = 2'($urandom_range(0, 3));
            end
        end
        check("latency", cyc, el);
        e = exp_q.pop_front();
        check("float", out_float, e[31:0]);
        check("inexact", out_inexact, e[32]);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_int = $urandom;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_float", out_float, e[31:0]);
            check("hold_inexact", out_inexact, e[32]);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_ready", in_ready, 1);
        check("release_valid", out_valid, 0);
    endtask

    task automatic run_ref(input logic [31:0] v, input logic [1:0] rm, input int hold);
        logic [32:0] r;
        r = ref_cvt(v, rm);
        run_op(v, rm, r[31:0], r[32], lat_ref(v), hold);
    endtask

    initial begin
        int cyc;
        bit seen;
        logic [31:0] v;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_int = 32'd0;
        in_rm = 2'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_float", out_float, 0);
        check("rst_inexact", out_inexact, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;

        // Directed cases with hand-derived results.
        run_op(32'h00000001, 2'd0, 32'h3F800000, 1'b0, 13, 0);
        run_op(32'hFFFFFFFF, 2'd0, 32'hBF800000, 1'b0, 13, 0);
        run_op(32'h80000000, 2'd0, 32'hCF000000, 1'b0, 3, 0);
        run_op(32'h7FFFFFFF, 2'd0, 32'h4F000000, 1'b1, 4, 0);
        run_op(32'h7FFFFFFF, 2'd1, 32'h4EFFFFFF, 1'b1, 4, 0);
        run_op(32'h01000001, 2'd0, 32'h4B800000, 1'b1, 10, 0);
        run_op(32'h01000001, 2'd2, 32'h4B800001, 1'b1, 10, 0);
        run_op(32'h01000001, 2'd1, 32'h4B800000, 1'b1, 10, 0);
        run_op(32'h01000001, 2'd3, 32'h4B800000, 1'b1, 10, 0);
        run_op(32'hFEFFFFFF, 2'd3, 32'hCB800001, 1'b1, 10, 0);
        run_op(32'hFEFFFFFF, 2'd2, 32'hCB800000, 1'b1, 10, 0);
        for (int m = 0; m < 4; m++) run_op(32'd0, 2'(m), 32'd0, 1'b0, 1, 0);
        run_op(32'd1000, 2'd0, 32'h447A0000, 1'b0, lat_ref(32'd1000), 5);

        // Flush while normalising: result must never appear.
        @(negedge clk);
        in_valid = 1'b1;
        in_int = 32'd1;
        in_rm = 2'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_ready", in_ready, 1);
        check("flush_valid", out_valid, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("flush_no_result", seen, 0);
        run_op(32'd3, 2'd0, 32'h40400000, 1'b0, lat_ref(32'd3), 0);

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        in_valid = 1'b1;
        in_int = 32'd7;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle_ready", in_ready, 1);
        check("flush_idle_valid", out_valid, 0);

        // Reset while holding a result in DONE.
        in_valid = 1'b1;
        in_int = 32'd5;
        in_rm = 2'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_done_reached", out_valid, 1);
        check("rst_done_float", out_float, 32'h40A00000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_done_valid", out_valid, 0);
        check("rst_done_zero", out_float, 0);
        check("rst_done_inexact", out_inexact, 0);
        check("rst_done_ready", in_ready, 1);

        // Randomized operands across all magnitudes, signs and modes.
        for (int k = 0; k < 200; k++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
            if ($urandom_range(0, 15) == 0) v = 32'd0;
            run_ref(v, 2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
